// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU request arbiter: state encoding, canonical
// quiet NaN and the bit positions of the {nan, inf, ovf, uf, zero} flag vector.
package fpu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP
  } arb_state_t;

  localparam logic [31:0] FPU_QNAN = 32'h7FC0_0000;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_UF   = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_INF  = 3;
  localparam int FLAG_NAN  = 4;

  localparam logic [4:0] TIMEOUT_FLAGS = 5'b1 << FLAG_NAN;

endpackage

// File: rtl/fpu_rr_pick.sv
// Combinational round-robin picker: selects the first asserted request at or
// after the pointer, wrapping at N. Usable by any shared-resource arbiter.
module fpu_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      pos = sum[IW-1:0];
      if (!any && req[pos]) begin
        any        = 1'b1;
        idx        = pos;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_req_arb.sv
// Round-robin arbiter/sequencer sharing one FPU datapath among NUM_REQ
// requesters: grant, issue with a one-cycle enable, wait with timeout, respond.
module fpu_req_arb
  import fpu_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int OPERAND_WIDTH  = 32,
  parameter int OPCODE_WIDTH   = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              fpu_clk,
  input  logic                              fpu_rst_n,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*OPCODE_WIDTH-1:0]   req_opcode_i,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0]  req_operand1_i,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0]  req_operand2_i,
  input  logic [NUM_REQ*3-1:0]              req_round_mode_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  input  logic [NUM_REQ-1:0]                rsp_ready_i,
  output logic [OPERAND_WIDTH-1:0]          rsp_result_o,
  output logic [4:0]                        rsp_flag_o,
  output logic                              rsp_timeout_o,
  output logic                              fpu_en_o,
  output logic [OPCODE_WIDTH-1:0]           fpu_opcode_o,
  output logic [OPERAND_WIDTH-1:0]          fpu_operand1_o,
  output logic [OPERAND_WIDTH-1:0]          fpu_operand2_o,
  output logic [2:0]                        fpu_round_mode_o,
  input  logic                              fpu_ready_i,
  input  logic [OPERAND_WIDTH-1:0]          fpu_result_i,
  input  logic [4:0]                        fpu_flag_i
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t state, state_next;

  logic [IW-1:0]            rr_ptr;
  logic [IW-1:0]            grant_idx;
  logic [CW-1:0]            wait_cnt;
  logic [NUM_REQ-1:0]       pick_grant;
  logic [IW-1:0]            pick_idx;
  logic                     pick_any;
  logic [OPCODE_WIDTH-1:0]  sel_opcode;
  logic [OPERAND_WIDTH-1:0] sel_operand1;
  logic [OPERAND_WIDTH-1:0] sel_operand2;
  logic [2:0]               sel_round_mode;
  logic                     accept;
  logic                     rsp_take;
  logic                     timeout_hit;

  fpu_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid_i),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_opcode     = '0;
    sel_operand1   = '0;
    sel_operand2   = '0;
    sel_round_mode = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_opcode     = req_opcode_i[i*OPCODE_WIDTH +: OPCODE_WIDTH];
        sel_operand1   = req_operand1_i[i*OPERAND_WIDTH +: OPERAND_WIDTH];
        sel_operand2   = req_operand2_i[i*OPERAND_WIDTH +: OPERAND_WIDTH];
        sel_round_mode = req_round_mode_i[i*3 +: 3];
      end
    end
  end

  assign accept      = (state == S_IDLE) && pick_any;
  assign rsp_take    = (state == S_RESP) && rsp_ready_i[grant_idx];
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
    if (!fpu_rst_n) state <= S_IDLE;
    else            state <= state_next;
  end

  // Ready takes priority over the timeout when both land in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pick_any) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (fpu_ready_i || timeout_hit) state_next = S_RESP;
      S_RESP:  if (rsp_take) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Grant is gated by reset so every output is quiet while reset is held.
  assign req_ready_o = (accept && fpu_rst_n) ? pick_grant : '0;
  assign rsp_valid_o = (state == S_RESP) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign fpu_en_o    = (state == S_ISSUE);

  always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
    if (!fpu_rst_n) begin
      rr_ptr           <= '0;
      grant_idx        <= '0;
      wait_cnt         <= '0;
      fpu_opcode_o     <= '0;
      fpu_operand1_o   <= '0;
      fpu_operand2_o   <= '0;
      fpu_round_mode_o <= '0;
      rsp_result_o     <= '0;
      rsp_flag_o       <= '0;
      rsp_timeout_o    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            grant_idx        <= pick_idx;
            fpu_opcode_o     <= sel_opcode;
            fpu_operand1_o   <= sel_operand1;
            fpu_operand2_o   <= sel_operand2;
            fpu_round_mode_o <= sel_round_mode;
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          if (fpu_ready_i) begin
            rsp_result_o  <= fpu_result_i;
            rsp_flag_o    <= fpu_flag_i;
            rsp_timeout_o <= 1'b0;
          end else if (timeout_hit) begin
            rsp_result_o  <= OPERAND_WIDTH'(FPU_QNAN);
            rsp_flag_o    <= TIMEOUT_FLAGS;
            rsp_timeout_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_take) begin
            if (grant_idx == IW'(NUM_REQ - 1)) rr_ptr <= '0;
            else                               rr_ptr <= grant_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_req_arb.sv
// Directed bench for fpu_req_arb: a table of commands with hand-computed grants
// and results, plus a hand-written reset-during-WAIT sequence.
module tb_fpu_req_arb;

  logic         fpu_clk;
  logic         fpu_rst_n;
  logic [3:0]   req_valid_i;
  logic [3:0]   req_ready_o;
  logic [19:0]  req_opcode_i;
  logic [127:0] req_operand1_i;
  logic [127:0] req_operand2_i;
  logic [11:0]  req_round_mode_i;
  logic [3:0]   rsp_valid_o;
  logic [3:0]   rsp_ready_i;
  logic [31:0]  rsp_result_o;
  logic [4:0]   rsp_flag_o;
  logic         rsp_timeout_o;
  logic         fpu_en_o;
  logic [4:0]   fpu_opcode_o;
  logic [31:0]  fpu_operand1_o;
  logic [31:0]  fpu_operand2_o;
  logic [2:0]   fpu_round_mode_o;
  logic         fpu_ready_i;
  logic [31:0]  fpu_result_i;
  logic [4:0]   fpu_flag_i;

  fpu_req_arb dut (
    .fpu_clk          (fpu_clk),
    .fpu_rst_n        (fpu_rst_n),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_opcode_i     (req_opcode_i),
    .req_operand1_i   (req_operand1_i),
    .req_operand2_i   (req_operand2_i),
    .req_round_mode_i (req_round_mode_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_result_o     (rsp_result_o),
    .rsp_flag_o       (rsp_flag_o),
    .rsp_timeout_o    (rsp_timeout_o),
    .fpu_en_o         (fpu_en_o),
    .fpu_opcode_o     (fpu_opcode_o),
    .fpu_operand1_o   (fpu_operand1_o),
    .fpu_operand2_o   (fpu_operand2_o),
    .fpu_round_mode_o (fpu_round_mode_o),
    .fpu_ready_i      (fpu_ready_i),
    .fpu_result_i     (fpu_result_i),
    .fpu_flag_i       (fpu_flag_i)
  );

  initial fpu_clk = 1'b0;
  always #5 fpu_clk = ~fpu_clk;

  typedef struct {
    logic [3:0]  mask;
    int          grant;
    int          latency;
    logic [31:0] res;
    logic [4:0]  flg;
    int          hold;
    bit          stale;
  } vec_t;

  int checks;
  int errors;

  logic [4:0]  op_tab [4];
  logic [31:0] a_tab  [4];
  logic [31:0] b_tab  [4];
  logic [2:0]  rm_tab [4];
  vec_t        vecs   [16];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready_o, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid_o, 0);
    checkOutput({tag, "_fpu_en"}, fpu_en_o, 0);
    checkOutput({tag, "_result"}, rsp_result_o, 0);
    checkOutput({tag, "_flags"}, rsp_flag_o, 0);
    checkOutput({tag, "_timeout"}, rsp_timeout_o, 0);
    checkOutput({tag, "_opcode"}, fpu_opcode_o, 0);
    checkOutput({tag, "_operands"}, {fpu_operand1_o, fpu_operand2_o}, 0);
    checkOutput({tag, "_round"}, fpu_round_mode_o, 0);
  endtask

  // One complete command: grant, issue, wait, optional backpressure, response.
  task automatic applyStimulus(input vec_t v);
    logic [31:0] exp_res;
    logic [4:0]  exp_flg;
    logic        exp_to;
    int          exp_waits;
    int          waits;
    int          en_extra;
    bit          got;
    int          g;
    g = v.grant;
    if (v.latency == 0) begin
      exp_res = 32'h7FC0_0000; exp_flg = 5'b10000; exp_to = 1'b1; exp_waits = 64;
    end else begin
      exp_res = v.res; exp_flg = v.flg; exp_to = 1'b0; exp_waits = v.latency;
    end

    @(negedge fpu_clk);
    req_valid_i  = v.mask;
    rsp_ready_i  = 4'b0000;
    fpu_ready_i  = v.stale;
    fpu_result_i = 32'hDEAD_BEEF;
    fpu_flag_i   = 5'b01111;
    #1;
    checkOutput("idle_grant", req_ready_o, 4'b0001 << g);
    checkOutput("idle_en", fpu_en_o, 0);

    @(posedge fpu_clk);
    @(negedge fpu_clk);
    #1;
    checkOutput("issue_en", fpu_en_o, 1);
    checkOutput("issue_req_ready", req_ready_o, 0);
    checkOutput("issue_opcode", fpu_opcode_o, op_tab[g]);
    checkOutput("issue_operands", {fpu_operand1_o, fpu_operand2_o}, {a_tab[g], b_tab[g]});
    checkOutput("issue_round", fpu_round_mode_o, rm_tab[g]);

    waits = 0; en_extra = 0; got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge fpu_clk);
      @(negedge fpu_clk);
      #1;
      if (rsp_valid_o != 4'b0000) begin
        got = 1;
      end else begin
        waits++;
        if (fpu_en_o) en_extra++;
        if (req_ready_o != 4'b0000) en_extra++;
        fpu_ready_i  = v.stale ? 1'b1 : (v.latency > 0 && waits == v.latency);
        fpu_result_i = v.res;
        fpu_flag_i   = v.flg;
      end
    end
    checkOutput("resp_reached", got, 1);
    checkOutput("wait_cycles", waits, exp_waits);
    checkOutput("wait_quiet", en_extra, 0);
    checkOutput("rsp_valid", rsp_valid_o, 4'b0001 << g);
    checkOutput("rsp_result", rsp_result_o, exp_res);
    checkOutput("rsp_flags", rsp_flag_o, exp_flg);
    checkOutput("rsp_timeout", rsp_timeout_o, exp_to);
    checkOutput("rsp_opcode_held", fpu_opcode_o, op_tab[g]);

    for (int h = 0; h < v.hold; h++) begin
      fpu_ready_i  = 1'b1;
      fpu_result_i = 32'h0BAD_0BAD;
      rsp_ready_i  = ~(4'b0001 << g);
      @(posedge fpu_clk);
      @(negedge fpu_clk);
      #1;
      checkOutput("hold_valid", rsp_valid_o, 4'b0001 << g);
      checkOutput("hold_result", rsp_result_o, exp_res);
      checkOutput("hold_no_grant", req_ready_o, 0);
    end

    rsp_ready_i = 4'b0001 << g;
    @(posedge fpu_clk);
    @(negedge fpu_clk);
    #1;
    checkOutput("resp_done", rsp_valid_o, 0);
    req_valid_i = 4'b0000;
    rsp_ready_i = 4'b0000;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    op_tab[0] = 5'b00011; a_tab[0] = 32'h3F80_0000; b_tab[0] = 32'h4000_0000; rm_tab[0] = 3'd1;
    op_tab[1] = 5'b00100; a_tab[1] = 32'h1111_1111; b_tab[1] = 32'h0A0A_0A0A; rm_tab[1] = 3'd2;
    op_tab[2] = 5'b00101; a_tab[2] = 32'h2222_2222; b_tab[2] = 32'h0B0B_0B0B; rm_tab[2] = 3'd3;
    op_tab[3] = 5'b00110; a_tab[3] = 32'h3333_3333; b_tab[3] = 32'h0C0C_0C0C; rm_tab[3] = 3'd4;
    for (int i = 0; i < 4; i++) begin
      req_opcode_i[i*5 +: 5]       = op_tab[i];
      req_operand1_i[i*32 +: 32]   = a_tab[i];
      req_operand2_i[i*32 +: 32]   = b_tab[i];
      req_round_mode_i[i*3 +: 3]   = rm_tab[i];
    end

    // Fairness: all four valid, grants rotate 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{4'b1111, i % 4, (i % 4) + 1, 32'hA000_0000 + i, 5'(i), 0, 1'b0};
    vecs[8]  = '{4'b0001, 0, 5, 32'h4040_0000, 5'b00000, 0,  1'b0};
    vecs[9]  = '{4'b0101, 2, 2, 32'h1234_5678, 5'b00001, 0,  1'b0};
    vecs[10] = '{4'b0011, 0, 3, 32'h8765_4321, 5'b00100, 0,  1'b0};
    vecs[11] = '{4'b1000, 3, 0, 32'h5555_5555, 5'b01000, 0,  1'b0};
    vecs[12] = '{4'b0110, 1, 2, 32'h3C00_0000, 5'b00000, 0,  1'b0};
    vecs[13] = '{4'b1111, 2, 1, 32'h4049_0FDB, 5'b00010, 10, 1'b0};
    vecs[14] = '{4'b1111, 3, 1, 32'h40A0_0000, 5'b00000, 0,  1'b1};
    vecs[15] = '{4'b0010, 1, 2, 32'h0000_0000, 5'b00001, 0,  1'b0};

    fpu_rst_n    = 1'b0;
    req_valid_i  = 4'b1111;
    rsp_ready_i  = 4'b0000;
    fpu_ready_i  = 1'b0;
    fpu_result_i = '0;
    fpu_flag_i   = '0;
    #12;
    checkAllZero("reset");
    @(negedge fpu_clk);
    req_valid_i = 4'b0000;
    fpu_rst_n   = 1'b1;
    @(negedge fpu_clk);
    #1;
    checkOutput("idle_no_req", req_ready_o, 0);

    for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);

    // Reset during WAIT: command on requester 2 is abandoned, pointer returns to 0.
    @(negedge fpu_clk);
    req_valid_i = 4'b0100;
    fpu_ready_i = 1'b0;
    #1;
    checkOutput("rst_seq_grant", req_ready_o, 4'b0100);
    repeat (3) @(negedge fpu_clk);
    req_valid_i = 4'b1111;
    fpu_rst_n   = 1'b0;
    #1;
    checkAllZero("midwait_reset");
    @(negedge fpu_clk);
    req_valid_i = 4'b0000;
    fpu_rst_n   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge fpu_clk);
      #1;
      checkOutput("post_reset_no_rsp", rsp_valid_o, 0);
    end
    applyStimulus('{4'b1111, 0, 3, 32'h3F00_0000, 5'b00000, 0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_req_arb.md
# fpu_req_arb

Round-robin arbiter and sequencer that shares one FPU datapath (decode, execute, encode) among `NUM_REQ` independent requesters. Each requester presents a complete command: opcode, two operands and a rounding mode. The block grants one command at a time, drives the FPU operand/opcode inputs, pulses the FPU enable, and waits for the encoder ready with a timeout guard. It then returns the result and flags to the granted requester only. It sits between requester-side logic and the FPU core, in place of direct register-file driving.

## Interface
**Parameters**
- `NUM_REQ`, 4: number of requesters (2–8).
- `OPERAND_WIDTH`, 32: operand/result width.
- `OPCODE_WIDTH`, 5: opcode width.
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles before forced abort (≥4).

**Ports**
- `fpu_clk`  in  1  clock; one clock domain.
- `fpu_rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NUM_REQ  command valid, one bit per requester.
- `req_ready_o`  out  NUM_REQ  command accepted, one-hot or zero.
- `req_opcode_i`  in  NUM_REQ*OPCODE_WIDTH  packed opcodes; requester i occupies slice i.
- `req_operand1_i`, `req_operand2_i`  in  NUM_REQ*OPERAND_WIDTH  packed operands.
- `req_round_mode_i`  in  NUM_REQ*3  packed rounding modes.
- `rsp_valid_o`  out  NUM_REQ  response valid, one-hot or zero.
- `rsp_ready_i`  in  NUM_REQ  response taken.
- `rsp_result_o`  out  OPERAND_WIDTH  shared result bus.
- `rsp_flag_o`  out  5  {nan, inf, ovf, uf, zero}.
- `rsp_timeout_o`  out  1  response was produced by timeout abort.
- `fpu_en_o`  out  1  single-cycle start pulse to the FPU control unit.
- `fpu_opcode_o`  out  OPCODE_WIDTH  opcode to FPU.
- `fpu_operand1_o`, `fpu_operand2_o`  out  OPERAND_WIDTH  operands to FPU.
- `fpu_round_mode_o`  out  3  rounding mode to FPU.
- `fpu_ready_i`  in  1  encoder ready (pulse or level).
- `fpu_result_i`  in  OPERAND_WIDTH  encoder result.
- `fpu_flag_i`  in  5  encoder flags.

## Operation
- **FSM states.** IDLE, ISSUE, WAIT, RESP.
- **IDLE.**
  - The winner is the first asserted `req_valid_i` at or after `rr_ptr`, scanning upward with wrap at NUM_REQ.
  - `req_ready_o[winner]=1` in the same cycle, combinationally.
  - On that edge: latch opcode, operands, mode and grant index; go to ISSUE.
  - With no valid request, stay in IDLE.
- **ISSUE.**
  - `fpu_en_o=1` for exactly one cycle.
  - Clear the timeout counter; go to WAIT.
  - `fpu_ready_i` is ignored in ISSUE, so stale ready from a previous op is masked.
- **WAIT.**
  - The counter increments each cycle.
  - First cycle with `fpu_ready_i=1`: capture `fpu_result_i` and `fpu_flag_i`, `rsp_timeout_o=0`, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES first: load result 32'h7FC0_0000, flags 5'b10000, `rsp_timeout_o=1`, go to RESP.
  - If ready and the limit occur in the same cycle, ready wins.
- **RESP.**
  - `rsp_valid_o[grant]=1` with the result held stable.
  - Leave on `rsp_valid_o[grant] & rsp_ready_i[grant]`: set `rr_ptr = grant+1` (mod NUM_REQ) and return to IDLE.
  - `rsp_ready_i` of non-granted requesters is ignored.
- **FPU outputs.** `fpu_opcode_o`, `fpu_operand*_o` and `fpu_round_mode_o` are registered and stable from ISSUE through RESP. They are not changed in IDLE.
- **Requester contract.** Command fields must stay stable while `req_valid_i` is high and not yet accepted. Dropping valid before accept is legal and simply removes that requester from arbitration.
- **Reset.** All outputs go to 0, `rr_ptr=0`, state IDLE, counter 0. A reset mid-operation abandons the command with no response. The FPU core is reset by the same `fpu_rst_n`.

## Timing
- Accept edge T0; `fpu_en_o` high during cycle T0+1.
- Earliest capture is `fpu_ready_i` at T0+2.
- Ready seen at cycle Tk gives `rsp_valid_o` high from Tk+1.
- Minimum turnaround:
  - response accepted in the first RESP cycle: the next accept is possible in the following cycle;
  - this gives 4 cycles per command plus the FPU latency.
- Only one command is in flight; there is no pipelining.
- `req_ready_o` is never asserted outside IDLE.

## Structure
- **Shared package `fpu_pkg`:**
  - state encoding localparams: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3;
  - canonical qNaN constant 32'h7FC0_0000;
  - flag bit index constants.
- **Sub-module `fpu_rr_pick`.** Combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, grant index and an any-valid flag.
  - Reusable by other shared-resource blocks.

## Test plan
- **Single add.** `req_valid_i=4'b0001`, opcode 5'b00011, operands 32'h3F80_0000 + 32'h4000_0000, FPU model ready after 5 cycles.
  - Expect `fpu_en_o` one pulse at T0+1.
  - Expect `rsp_valid_o=4'b0001`, result 32'h4040_0000, `rsp_timeout_o=0`.
- **Fairness.** All four requesters valid continuously for 8 commands.
  - Expect grant order 0,1,2,3,0,1,2,3.
  - Expect `req_ready_o` always one-hot.
- **Timeout.** FPU model never asserts ready.
  - Expect RESP after 64 WAIT cycles with result 32'h7FC0_0000, flags 5'b10000, `rsp_timeout_o=1`.
  - Expect the next request to be served normally.
- **Response backpressure and stale ready.** Hold `rsp_ready_i[2]=0` for 10 cycles while `fpu_ready_i` stays high.
  - Expect the result to be held, no new grant, and the next op's ISSUE cycle to ignore the stale ready.
- **Reset mid-WAIT.** Assert `fpu_rst_n=0` during WAIT.
  - Expect all outputs 0 immediately, no response, and grant priority restarting at requester 0.
